oam_dma: RTL and testbench
==========================

# oam_dma

CPU-side sprite DMA sequencer for the `$4014` OAMDMA register. A CPU write to `$4014` starts the transfer. The block then stalls the CPU and copies 256 bytes from page `$XX00–$XXFF` into PPU OAM through repeated writes to `$2004`. It sits beside the PPU register file on the CPU bus and drives the `dma_hijack`/`dma_addr` path that the bus mux uses to take over the CPU's address, data and write strobe.

## Interface
Parameters:
- `DMA_REG_ADDR`, default `16'h4014`: CPU address that triggers a transfer.
- `OAM_DATA_ADDR`, default `16'h2004`: destination register address for every DMA write.

Ports:
- `clk`, in, 1: CPU clock (`cpu_clk` domain).
- `reset`, in, 1: reset, synchronous, active-high.
- `bus_addr`, in, 16: CPU bus address.
- `bus_din`, in, 8: CPU write data.
- `bus_wr`, in, 1: CPU write strobe.
- `bus_rdata`, in, 8: read data returned from the address driven on the previous cycle (synchronous RAM).
- `odd_or_even`, in, 1: 1 means the current CPU cycle is odd.
- `dma_hijack`, out, 1: 1 means the bus mux selects the `dma_*` outputs and the CPU is stalled.
- `dma_addr`, out, 16: DMA bus address.
- `dma_wr`, out, 1: DMA write strobe.
- `dma_dout`, out, 8: DMA write data.
- `busy`, out, 1: equals `dma_hijack`; exported for status and debug.

## Operation
- **States:** IDLE, HALT, ALIGN, READ, WRITE.
- **Registers:** `page[7:0]` (source page), `idx[7:0]` (byte counter).
- **IDLE:** on `bus_wr && bus_addr==DMA_REG_ADDR`, latch `page<=bus_din`, clear `idx<=0`, go to HALT. All other bus traffic is ignored.
- **HALT:** one dummy cycle. Go to ALIGN if `odd_or_even==1` in this cycle, otherwise go to READ.
- **ALIGN:** one extra dummy cycle, then go to READ.
- **READ:**
  - Drives `dma_addr={page,idx}`, `dma_wr=0`.
  - Goes to WRITE.
- **WRITE:**
  - Drives `dma_addr=OAM_DATA_ADDR`, `dma_wr=1`, `dma_dout=bus_rdata` (combinational pass-through; the data is valid this cycle).
  - If `idx==8'hFF`, go to IDLE. Otherwise `idx<=idx+1` and go to READ.
- **Width rules:**
  - `idx` is 8 bits and wraps. It never carries into `page`.
  - Page `$FF` transfers `$FF00–$FFFF` only.
- **Writes to `DMA_REG_ADDR` while not IDLE:** ignored; `page` is unchanged and no restart occurs.
- **Output values by state:**
  - HALT/ALIGN: `dma_addr={page,8'h00}`, `dma_wr=0`.
  - IDLE: `dma_addr=0`, `dma_wr=0`, `dma_dout=0`.
- **Reset:** valid in any state, including mid-transfer. The block goes to IDLE with `page=0`, `idx=0`. A partial transfer is abandoned; OAM keeps whatever was already written.
- **Reset values of outputs:**
  - `dma_hijack=0`, `busy=0`, `dma_wr=0`.
  - `dma_addr=16'h0000`, `dma_dout=8'h00`.

## Timing
- The trigger write in cycle T is sampled at the edge ending T.
- `dma_hijack` is 1 from T+1 through the final WRITE cycle inclusive, and 0 in IDLE.
- Hijack duration depends on parity in the HALT cycle:
  - Even: 1 + 512 = 513 cycles.
  - Odd: 1 + 1 + 512 = 514 cycles.
- The first READ is at T+2 (even) or T+3 (odd). Byte k is written to OAM in the WRITE cycle at READ0 + 2k + 1.
- `dma_hijack` falls on the cycle after the last WRITE. That cycle is IDLE and may accept a new trigger, so back-to-back transfers are allowed.
- Outputs are registered-state decodes. Only `dma_dout` is combinational, from `bus_rdata`.

## Structure
- Shared package `ppu_pkg` holds:
  - the state enum `dma_state_t` (IDLE, HALT, ALIGN, READ, WRITE);
  - constants `OAMDMA_ADDR=16'h4014`, `OAMDATA_ADDR=16'h2004`, `OAM_BYTES=256`.
- Single module with no sub-module. The counter and FSM are inline.

## Test plan
- **Even start:** `odd_or_even=0` in HALT, write `$4014<=8'h02`, source RAM `$0200+k = k^8'hA5`.
  - Required: exactly 513 cycles of `dma_hijack`.
  - Required: 256 `dma_wr` pulses to `$2004` with data `k^8'hA5` in order k=0..255.
- **Odd start:** same setup with `odd_or_even=1` in HALT.
  - Required: 514 hijack cycles.
  - Required: first READ address `$0200` appears 3 cycles after the trigger.
- **Retrigger ignored:** force `bus_wr=1`, `bus_addr=$4014`, `bus_din=8'h07` during byte 50.
  - Required: transfer continues from page `$02`; total length unchanged.
- **Reset mid-transfer:** assert `reset` in the WRITE of byte 100.
  - Required next cycle: `dma_hijack=0`, `dma_wr=0`, `dma_addr=0`.
  - Required: a new `$4014<=8'h03` then transfers `$0300–$03FF` starting at `idx` 0.
- **Page `$FF`:** write `$4014<=8'hFF`.
  - Required: READ addresses run `$FF00` to `$FFFF`, then the block returns to IDLE with no access to `$0000`.
- **Back-to-back:** issue a second `$4014<=8'h04` in the first IDLE cycle after a transfer.
  - Required: accepted; `dma_hijack` re-asserts on the following cycle.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: DMA state encoding and register map.
// Constants used by the OAM DMA sequencer and its neighbours.
package ppu_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
    localparam int          OAM_BYTES    = 256;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA sequencer: a CPU write to $4014 stalls the CPU and copies one
// 256-byte page into OAM through repeated writes to $2004.
// Ports:
//   clk, reset      : CPU clock, synchronous active-high reset
//   bus_addr/din/wr : CPU bus, watched for the trigger write
//   bus_rdata       : RAM data for the address driven last cycle
//   odd_or_even     : 1 on odd CPU cycles
//   dma_hijack/busy : bus mux select / status (CPU stalled)
//   dma_addr/wr/dout: DMA-side bus drive
module oam_dma
    import ppu_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = OAMDMA_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = OAMDATA_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    input  logic        bus_wr,
    input  logic [7:0]  bus_rdata,
    input  logic        odd_or_even,
    output logic        dma_hijack,
    output logic [15:0] dma_addr,
    output logic        dma_wr,
    output logic [7:0]  dma_dout,
    output logic        busy
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic       trigger;

    assign trigger = bus_wr && (bus_addr == DMA_REG_ADDR);

    // Outputs are registered together with the state they belong to,
    // so each branch loads the values of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DMA_IDLE;
            page       <= 8'h00;
            idx        <= 8'h00;
            dma_hijack <= 1'b0;
            dma_addr   <= 16'h0000;
            dma_wr     <= 1'b0;
        end else begin
            unique case (state)
                DMA_IDLE: begin
                    if (trigger) begin
                        state      <= DMA_HALT;
                        page       <= bus_din;
                        idx        <= 8'h00;
                        dma_hijack <= 1'b1;
                        dma_addr   <= {bus_din, 8'h00};
                        dma_wr     <= 1'b0;
                    end
                end
                DMA_HALT: begin
                    // idx is still zero here, so both paths drive {page,00}
                    dma_addr <= {page, idx};
                    if (odd_or_even) begin
                        state <= DMA_ALIGN;
                    end else begin
                        state <= DMA_READ;
                    end
                end
                DMA_ALIGN: begin
                    state    <= DMA_READ;
                    dma_addr <= {page, idx};
                end
                DMA_READ: begin
                    state    <= DMA_WRITE;
                    dma_addr <= OAM_DATA_ADDR;
                    dma_wr   <= 1'b1;
                end
                DMA_WRITE: begin
                    dma_wr <= 1'b0;
                    if (idx == LAST_IDX) begin
                        // idx stays at $FF: no wrap into a $xx00 access
                        state      <= DMA_IDLE;
                        dma_hijack <= 1'b0;
                        dma_addr   <= 16'h0000;
                    end else begin
                        state    <= DMA_READ;
                        idx      <= idx + 8'h01;
                        dma_addr <= {page, idx + 8'h01};
                    end
                end
                default: begin
                    state      <= DMA_IDLE;
                    dma_hijack <= 1'b0;
                    dma_addr   <= 16'h0000;
                    dma_wr     <= 1'b0;
                end
            endcase
        end
    end

    // RAM answers one cycle after the READ address, i.e. during WRITE.
    always_comb begin
        dma_dout = 8'h00;
        if (dma_wr) begin
            dma_dout = bus_rdata;
        end
    end

    assign busy = dma_hijack;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: random RAM contents, random CPU traffic,
// compared against a page-copy reference model kept in the bench.
module tb_oam_dma;

    logic        clk;
    logic        reset;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic        bus_wr;
    logic [7:0]  bus_rdata;
    logic        odd_or_even;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic        dma_wr;
    logic [7:0]  dma_dout;
    logic        busy;

    int total;
    int bad;

    logic [7:0]  mem [65536];
    logic [15:0] last_addr;
    logic [15:0] prev_addr;
    logic [7:0]  wd[$];
    logic [15:0] ra[$];
    int          ncyc;
    int          hij;
    int          trig_n;
    int          first_wr_n;
    int          wa_bad;
    int          busy_bad;
    logic        halt_par;

    oam_dma dut (
        .clk        (clk),
        .reset      (reset),
        .bus_addr   (bus_addr),
        .bus_din    (bus_din),
        .bus_wr     (bus_wr),
        .bus_rdata  (bus_rdata),
        .odd_or_even(odd_or_even),
        .dma_hijack (dma_hijack),
        .dma_addr   (dma_addr),
        .dma_wr     (dma_wr),
        .dma_dout   (dma_dout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // End the current cycle; RAM returns data for last cycle's address.
    task automatic cyc_tick();
        @(posedge clk);
        #1;
        bus_rdata   = mem[last_addr];
        odd_or_even = ~odd_or_even;
        ncyc++;
    endtask

    task automatic quiet_bus();
        bus_wr   = 1'b0;
        bus_addr = 16'($urandom);
        if (bus_addr == 16'h4014) bus_addr = 16'h4015;
        bus_din  = 8'($urandom);
    endtask

    // Mid-cycle observation of the DMA side of the bus.
    task automatic sample();
        @(negedge clk);
        last_addr = dma_hijack ? dma_addr : bus_addr;
        if (busy !== dma_hijack) busy_bad++;
        if (dma_hijack) hij++;
        if (dma_wr) begin
            if (dma_addr !== 16'h2004) wa_bad++;
            if (wd.size() == 0) first_wr_n = ncyc;
            wd.push_back(dma_dout);
            ra.push_back(prev_addr);
        end
        prev_addr = dma_addr;
    endtask

    task automatic clear_log();
        wd.delete();
        ra.delete();
        hij        = 0;
        wa_bad     = 0;
        first_wr_n = -1;
    endtask

    // Random traffic until the parity is right, then the $4014 write.
    task automatic trigger(input logic [7:0] pg, input logic want_odd);
        int n;
        n = 0;
        while (odd_or_even !== ~want_odd || n < 2) begin
            bus_wr   = 1'($urandom);
            bus_addr = 16'($urandom);
            if (bus_addr == 16'h4014) bus_addr = 16'h4016;
            sample();
            cyc_tick();
            n++;
        end
        clear_log();
        bus_wr   = 1'b1;
        bus_addr = 16'h4014;
        bus_din  = pg;
        trig_n   = ncyc;
        sample();
        cyc_tick();
        quiet_bus();
    endtask

    // Runs the transfer after the trigger; leaves off after sampling the
    // first IDLE cycle (or the cycle after a mid-transfer reset).
    task automatic body(input logic retrig, input logic rst_mid,
                        output logic was_reset);
        logic done;
        logic first;
        done      = 1'b0;
        first     = 1'b1;
        was_reset = 1'b0;
        for (int i = 0; i < 700; i++) begin
            sample();
            if (first) begin
                halt_par = odd_or_even;
                first    = 1'b0;
            end
            if (!dma_hijack) begin
                done = 1'b1;
                chk("idle_addr", 32'(dma_addr), 32'h0);
                chk("idle_dout", 32'(dma_dout), 32'h0);
                break;
            end
            if (retrig && !dma_wr && wd.size() == 50) begin
                bus_wr   = 1'b1;
                bus_addr = 16'h4014;
                bus_din  = 8'h07;
            end
            if (rst_mid && dma_wr && wd.size() == 101) begin
                reset = 1'b1;
                cyc_tick();
                reset = 1'b0;
                sample();
                chk("rst_hijack", 32'(dma_hijack), 32'h0);
                chk("rst_wr", 32'(dma_wr), 32'h0);
                chk("rst_addr", 32'(dma_addr), 32'h0);
                was_reset = 1'b1;
                done      = 1'b1;
                break;
            end
            cyc_tick();
            quiet_bus();
        end
        if (!done) chk("timeout", 32'h0, 32'h1);
    endtask

    // Reference: 256 bytes of the page, in order, each read from {page,k}.
    task automatic check_copy(input string tag, input logic [7:0] pg);
        int nd;
        int na;
        nd = 0;
        na = 0;
        chk({tag, "_nwr"}, 32'(wd.size()), 32'd256);
        for (int k = 0; k < wd.size() && k < 256; k++) begin
            if (wd[k] !== mem[{pg, 8'(k)}]) nd++;
            if (ra[k] !== {pg, 8'(k)}) na++;
        end
        chk({tag, "_data"}, 32'(nd), 32'h0);
        chk({tag, "_raddr"}, 32'(na), 32'h0);
        chk({tag, "_waddr"}, 32'(wa_bad), 32'h0);
        chk({tag, "_hij"}, 32'(hij), 32'(513 + int'(halt_par)));
        chk({tag, "_lat"}, 32'(first_wr_n - trig_n),
            32'(3 + int'(halt_par)));
    endtask

    initial begin
        logic rs;
        total       = 0;
        bad         = 0;
        ncyc        = 0;
        busy_bad    = 0;
        last_addr   = 16'h0;
        prev_addr   = 16'h0;
        halt_par    = 1'b0;
        reset       = 1'b1;
        bus_wr      = 1'b0;
        bus_addr    = 16'h0;
        bus_din     = 8'h0;
        bus_rdata   = 8'h0;
        odd_or_even = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < 256; k++) mem[16'h0200 + k] = 8'(k) ^ 8'hA5;
        clear_log();

        cyc_tick();
        cyc_tick();
        sample();
        chk("reset_hijack", 32'(dma_hijack), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_wr", 32'(dma_wr), 32'h0);
        chk("reset_addr", 32'(dma_addr), 32'h0);
        chk("reset_dout", 32'(dma_dout), 32'h0);
        cyc_tick();
        reset = 1'b0;

        // even start
        trigger(8'h02, 1'b0);
        body(1'b0, 1'b0, rs);
        chk("even_par", 32'(halt_par), 32'h0);
        check_copy("even", 8'h02);
        cyc_tick();

        // odd start
        trigger(8'h02, 1'b1);
        body(1'b0, 1'b0, rs);
        chk("odd_par", 32'(halt_par), 32'h1);
        check_copy("odd", 8'h02);
        chk("odd_first_read", 32'(ra[0]), 32'h0200);
        cyc_tick();

        // retrigger during byte 50 is ignored
        trigger(8'h02, 1'($urandom));
        body(1'b1, 1'b0, rs);
        check_copy("retrig", 8'h02);
        cyc_tick();

        // reset during WRITE of byte 100, then a fresh page $03
        trigger(8'h05, 1'($urandom));
        body(1'b0, 1'b1, rs);
        chk("rst_taken", 32'(rs), 32'h1);
        chk("rst_partial", 32'(wd.size()), 32'd101);
        cyc_tick();
        trigger(8'h03, 1'($urandom));
        body(1'b0, 1'b0, rs);
        check_copy("after_rst", 8'h03);
        cyc_tick();

        // page $FF stops at $FFFF
        trigger(8'hFF, 1'($urandom));
        body(1'b0, 1'b0, rs);
        check_copy("pgff", 8'hFF);
        chk("pgff_last", 32'(ra[ra.size()-1]), 32'hFFFF);

        // back-to-back: trigger in the first IDLE cycle
        clear_log();
        bus_wr   = 1'b1;
        bus_addr = 16'h4014;
        bus_din  = 8'h04;
        trig_n   = ncyc;
        cyc_tick();
        quiet_bus();
        body(1'b0, 1'b0, rs);
        chk("b2b_start", 32'(hij > 0), 32'h1);
        check_copy("b2b", 8'h04);

        chk("busy_eq_hijack", 32'(busy_bad), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
